tile_resolver: RTL and testbench
================================

Name: tile_resolver

Overview:
Responder side of the player move-request handshake. It samples a move request (ask_move, ask_x, ask_y), reads the target tile from map block RAM, and applies game rules: walls, keys, doors, monsters and potions. It then returns a one-cycle accept or reject with the resulting position, key count and health, and clears consumed tiles in the map RAM. It sits between the player movement logic and the map bRAM port.

Parameters:
MAP_BASE, 0, bRAM word address of tile (0,0); tile address = MAP_BASE + {y[3:0], x[3:0]}
GRID_W, 13, tiles per row; ask_x >= GRID_W is rejected
GRID_H, 13, rows; ask_y >= GRID_H is rejected
RD_LAT, 2, bRAM read latency in cycles, allowed range 1..4
MONSTER_DMG, 3, health lost on entering a monster tile
POTION_HEAL, 5, health gained on entering a potion tile
HEALTH_MAX, 10, health saturation ceiling

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ask_move  in  1  one-cycle move request pulse
ask_x  in  4  requested target x
ask_y  in  4  requested target y
player_x  in  4  current player x
player_y  in  4  current player y
key_num  in  4  current key count
health  in  8  current health
accept_move  out  1  one-cycle pulse, move accepted
reject_move  out  1  one-cycle pulse, move refused
busy  out  1  high from request sample until the response pulse, inclusive
goto_x  out  4  accepted target x
goto_y  out  4  accepted target y
key_num_out  out  4  key count after the move
health_out  out  8  health after the move
bRAM_map_addr  out  19  map RAM address
bRAM_map_data  in  16  map RAM read data
bRAM_map_wr  out  1  map RAM write enable
bRAM_map_dwrite  out  16  map RAM write data

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. On reset, every output is 0, except bRAM_map_addr = MAP_BASE. FSM returns to IDLE and any in-flight request is discarded: no response pulse, no write.
- Tile code is bRAM_map_data[3:0]:
  - 0 FLOOR, 1 WALL, 2 KEY, 3 DOOR, 4 MONSTER, 5 POTION.
  - Codes 6..15 are treated as WALL.
- FSM states: IDLE, PRECHK, READ, DECIDE, WRITE, RESP.
- IDLE:
  - On ask_move = 1, latch ask_x, ask_y, player_x, player_y, key_num and health, then go to PRECHK.
  - ask_move while busy = 1 is ignored and not queued.
- PRECHK (1 cycle):
  - Reject if the target is outside the grid.
  - Reject if the target is not 4-adjacent, i.e. |dx| + |dy| != 1 (this covers the same-tile case).
  - On reject go to RESP with reject; otherwise drive bRAM_map_addr and go to READ.
- READ: wait RD_LAT cycles, holding the address constant, then capture the tile word and go to DECIDE.
- DECIDE, all arithmetic on latched inputs:
  - FLOOR: accept, no change.
  - WALL: reject.
  - KEY: accept; key_num_out = min(key_num + 1, 15); tile consumed.
  - DOOR: if key_num >= 1, accept, key_num_out = key_num - 1, tile consumed; else reject.
  - MONSTER: if health > MONSTER_DMG, accept, health_out = health - MONSTER_DMG, tile consumed; else reject with health unchanged (no suicide moves).
  - POTION: accept; health_out = min(health + POTION_HEAL, HEALTH_MAX); tile consumed. Compute at 9-bit width before saturating.
- Routing out of DECIDE: a consumed tile goes to WRITE; anything else goes to RESP.
- WRITE (1 cycle):
  - bRAM_map_wr = 1 and bRAM_map_dwrite = {tile[15:4], 4'h0}, so the upper bits are preserved.
  - bRAM_map_addr stays at the target address.
- RESP (1 cycle):
  - Exactly one of accept_move or reject_move is 1.
  - key_num_out, health_out, goto_x and goto_y are registered and held until the next response.
  - On reject: key_num_out and health_out equal the latched inputs; goto equals the latched player position.
  - Return to IDLE, where a new ask_move is accepted on the next cycle.
- Latency from the edge that samples ask_move:
  - Geometric reject: 2 cycles.
  - Read-and-reject or no-consume accept: RD_LAT + 3 cycles.
  - Consumed-tile accept: RD_LAT + 4 cycles.
- bRAM_map_wr is 1 only in WRITE. It is never asserted in a cycle where rst = 1.

Decomposition:
- Shared package map_pkg:
  - Tile code constants TILE_FLOOR through TILE_POTION.
  - The FSM state encoding.
  - Tile address helper widths (19-bit address, 16-bit word).
  - These constants are reused by map rendering and map initialisation.
- One sub-module: move_precheck, combinational. It performs the bounds and adjacency check and produces the target address.

Test Plan:
1. Player (3,3), ask (4,3), tile FLOOR, RD_LAT = 2 -> accept_move 5 cycles after sample; goto (4,3); key and health unchanged; no write.
2. Ask (5,3) from (3,3), and separately ask (13,0) -> reject_move 2 cycles after sample; no bRAM read; outputs equal inputs.
3. Tile KEY 0x1232, key_num 15 -> accept; key_num_out 15 (saturated); write of 0x1230 in the cycle before accept.
4. DOOR with key_num 0 -> reject, no write. DOOR with key_num 2 -> accept, key_num_out 1, write issued.
5. MONSTER with health 3 -> reject. MONSTER with health 10 -> accept, health 7. POTION with health 7 -> health 10 (saturated).
6. Second ask_move during READ -> ignored, exactly one response. Assert rst during READ -> no pulse, no write, next request serviced normally.

Source files
------------

// File: rtl/map_pkg.sv
// Shared map definitions: tile codes, resolver FSM encoding and map RAM
// address/word widths. Map rendering and map initialisation reuse these too.
package map_pkg;

  localparam int ADDR_W = 19;
  localparam int WORD_W = 16;

  localparam logic [3:0] TILE_FLOOR   = 4'd0;
  localparam logic [3:0] TILE_WALL    = 4'd1;
  localparam logic [3:0] TILE_KEY     = 4'd2;
  localparam logic [3:0] TILE_DOOR    = 4'd3;
  localparam logic [3:0] TILE_MONSTER = 4'd4;
  localparam logic [3:0] TILE_POTION  = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRECHK, ST_READ, ST_DECIDE, ST_WRITE, ST_RESP
  } state_e;

  // Word address of tile (x,y): row-major with a 16-tile row pitch.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [3:0] x,
                                                  input logic [3:0] y);
    return base + {11'd0, y, x};
  endfunction

endpackage

// File: rtl/tile_resolver_if.sv
// Move-request handshake plus map RAM port of the tile resolver.
//   master: player/movement side and RAM (drives request, RAM read data)
//   slave : resolver (drives response, RAM address/write)
interface tile_resolver_if;
  import map_pkg::*;

  logic              ask_move;
  logic [3:0]        ask_x, ask_y;
  logic [3:0]        player_x, player_y;
  logic [3:0]        key_num;
  logic [7:0]        health;
  logic              accept_move, reject_move, busy;
  logic [3:0]        goto_x, goto_y;
  logic [3:0]        key_num_out;
  logic [7:0]        health_out;
  logic [ADDR_W-1:0] bRAM_map_addr;
  logic [WORD_W-1:0] bRAM_map_data;
  logic              bRAM_map_wr;
  logic [WORD_W-1:0] bRAM_map_dwrite;

  modport master (
    output ask_move, ask_x, ask_y, player_x, player_y, key_num, health, bRAM_map_data,
    input  accept_move, reject_move, busy, goto_x, goto_y, key_num_out, health_out,
           bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite
  );

  modport slave (
    input  ask_move, ask_x, ask_y, player_x, player_y, key_num, health, bRAM_map_data,
    output accept_move, reject_move, busy, goto_x, goto_y, key_num_out, health_out,
           bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite
  );

endinterface

// File: rtl/move_precheck.sv
// Combinational geometry check for a move request.
//   in : ask_x/ask_y target, player_x/player_y current position
//   out: ok   - target inside the grid and exactly one step (4-adjacent)
//        addr - map RAM word address of the target tile
module move_precheck import map_pkg::*; #(
  parameter int                GRID_W   = 13,
  parameter int                GRID_H   = 13,
  parameter logic [ADDR_W-1:0] MAP_BASE = '0
) (
  input  logic [3:0]        ask_x,
  input  logic [3:0]        ask_y,
  input  logic [3:0]        player_x,
  input  logic [3:0]        player_y,
  output logic              ok,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [4:0] GW = 5'(GRID_W);
  localparam logic [4:0] GH = 5'(GRID_H);

  logic [3:0] dx, dy;
  logic       in_grid, adj;

  always_comb begin
    dx      = (ask_x >= player_x) ? ask_x - player_x : player_x - ask_x;
    dy      = (ask_y >= player_y) ? ask_y - player_y : player_y - ask_y;
    in_grid = ({1'b0, ask_x} < GW) && ({1'b0, ask_y} < GH);
    // |dx|+|dy| == 1; the same-tile case fails here as well
    adj     = (dx == 4'd1 && dy == 4'd0) || (dx == 4'd0 && dy == 4'd1);
    ok      = in_grid && adj;
    addr    = tile_addr(MAP_BASE, ask_x, ask_y);
  end

endmodule

// File: rtl/tile_resolver.sv
// Responder for player move requests. Samples a request, checks geometry,
// reads the target tile, applies wall/key/door/monster/potion rules, clears
// consumed tiles in the map RAM and returns a one-cycle accept/reject pulse
// with the resulting position, key count and health.
//   clk, rst : clock, synchronous active-high reset
//   io       : move handshake + map RAM port (slave side)
// All handshake outputs are registered from the state they belong to, so each
// appears one cycle after that state (RESP -> pulse, WRITE -> RAM write).
module tile_resolver import map_pkg::*; #(
  parameter logic [ADDR_W-1:0] MAP_BASE    = '0,
  parameter int                GRID_W      = 13,
  parameter int                GRID_H      = 13,
  parameter int                RD_LAT      = 2,
  parameter int                MONSTER_DMG = 3,
  parameter int                POTION_HEAL = 5,
  parameter int                HEALTH_MAX  = 10
) (
  input  logic           clk,
  input  logic           rst,
  tile_resolver_if.slave io
);

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);
  localparam logic [7:0] DMG     = 8'(MONSTER_DMG);
  localparam logic [8:0] HEAL    = 9'(POTION_HEAL);
  localparam logic [8:0] HMAX    = 9'(HEALTH_MAX);

  state_e            state_q, state_d;
  logic [3:0]        ax_q, ax_d, ay_q, ay_d, px_q, px_d, py_q, py_d, key_q, key_d;
  logic [7:0]        hp_q, hp_d;
  logic [WORD_W-1:0] tile_q, tile_d;
  logic [1:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              res_acc_q, res_acc_d;
  logic [3:0]        res_key_q, res_key_d;
  logic [7:0]        res_hp_q, res_hp_d;
  logic              accept_q, accept_d, reject_q, reject_d, busy_q, busy_d;
  logic [3:0]        gx_q, gx_d, gy_q, gy_d, key_out_q, key_out_d;
  logic [7:0]        hp_out_q, hp_out_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] dwrite_q, dwrite_d;

  logic              pc_ok, consume;
  logic [ADDR_W-1:0] pc_addr;
  logic [8:0]        hp_sum;

  move_precheck #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAP_BASE(MAP_BASE)) u_precheck (
    .ask_x(ax_q), .ask_y(ay_q), .player_x(px_q), .player_y(py_q),
    .ok(pc_ok), .addr(pc_addr)
  );

  always_comb begin
    state_d   = state_q;
    ax_d = ax_q; ay_d = ay_q; px_d = px_q; py_d = py_q; key_d = key_q; hp_d = hp_q;
    tile_d    = tile_q;
    rd_cnt_d  = rd_cnt_q;
    addr_d    = addr_q;
    res_acc_d = res_acc_q;
    res_key_d = res_key_q;
    res_hp_d  = res_hp_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    gx_d = gx_q; gy_d = gy_q; key_out_d = key_out_q; hp_out_d = hp_out_q;
    wr_d      = 1'b0;
    dwrite_d  = dwrite_q;
    consume   = 1'b0;
    hp_sum    = {1'b0, hp_q} + HEAL;

    unique case (state_q)
      ST_IDLE: if (io.ask_move) begin
        ax_d = io.ask_x; ay_d = io.ask_y; px_d = io.player_x; py_d = io.player_y;
        key_d = io.key_num; hp_d = io.health;
        state_d = ST_PRECHK;
      end
      ST_PRECHK: begin
        // default result is a reject that leaves everything as it was
        res_acc_d = 1'b0;
        res_key_d = key_q;
        res_hp_d  = hp_q;
        if (pc_ok) begin
          addr_d   = pc_addr;
          rd_cnt_d = 2'd0;
          state_d  = ST_READ;
        end else begin
          state_d  = ST_RESP;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == RD_LAST) begin
          tile_d  = io.bRAM_map_data;
          state_d = ST_DECIDE;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      ST_DECIDE: begin
        case (tile_q[3:0])
          TILE_FLOOR: res_acc_d = 1'b1;
          TILE_KEY: begin
            res_acc_d = 1'b1;
            res_key_d = (key_q == 4'hF) ? 4'hF : key_q + 4'd1;
            consume   = 1'b1;
          end
          TILE_DOOR: if (key_q != 4'd0) begin
            res_acc_d = 1'b1;
            res_key_d = key_q - 4'd1;
            consume   = 1'b1;
          end
          TILE_MONSTER: if (hp_q > DMG) begin
            res_acc_d = 1'b1;
            res_hp_d  = hp_q - DMG;
            consume   = 1'b1;
          end
          TILE_POTION: begin
            res_acc_d = 1'b1;
            res_hp_d  = (hp_sum > HMAX) ? HMAX[7:0] : hp_sum[7:0];
            consume   = 1'b1;
          end
          default: ; // wall and unknown codes block the move
        endcase
        state_d = consume ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        wr_d     = 1'b1;
        dwrite_d = {tile_q[15:4], 4'h0};
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        accept_d  = res_acc_q;
        reject_d  = ~res_acc_q;
        key_out_d = res_key_q;
        hp_out_d  = res_hp_q;
        gx_d      = res_acc_q ? ax_q : px_q;
        gy_d      = res_acc_q ? ay_q : py_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // busy covers the whole transaction including the response pulse cycle
    busy_d = (state_d != ST_IDLE) || accept_d || reject_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ax_q <= '0; ay_q <= '0; px_q <= '0; py_q <= '0; key_q <= '0; hp_q <= '0;
      tile_q <= '0; rd_cnt_q <= '0; addr_q <= MAP_BASE;
      res_acc_q <= 1'b0; res_key_q <= '0; res_hp_q <= '0;
      accept_q <= 1'b0; reject_q <= 1'b0; busy_q <= 1'b0;
      gx_q <= '0; gy_q <= '0; key_out_q <= '0; hp_out_q <= '0;
      wr_q <= 1'b0; dwrite_q <= '0;
    end else begin
      state_q <= state_d;
      ax_q <= ax_d; ay_q <= ay_d; px_q <= px_d; py_q <= py_d; key_q <= key_d; hp_q <= hp_d;
      tile_q <= tile_d; rd_cnt_q <= rd_cnt_d; addr_q <= addr_d;
      res_acc_q <= res_acc_d; res_key_q <= res_key_d; res_hp_q <= res_hp_d;
      accept_q <= accept_d; reject_q <= reject_d; busy_q <= busy_d;
      gx_q <= gx_d; gy_q <= gy_d; key_out_q <= key_out_d; hp_out_q <= hp_out_d;
      wr_q <= wr_d; dwrite_q <= dwrite_d;
    end
  end

  // The address goes out during PRECHK itself so the RAM latency starts
  // counting on the PRECHK->READ edge; a rejected move never moves it.
  assign io.bRAM_map_addr   = (state_q == ST_PRECHK && pc_ok) ? pc_addr : addr_q;
  assign io.bRAM_map_wr     = wr_q & ~rst;
  assign io.bRAM_map_dwrite = dwrite_q;
  assign io.accept_move     = accept_q;
  assign io.reject_move     = reject_q;
  assign io.busy            = busy_q;
  assign io.goto_x          = gx_q;
  assign io.goto_y          = gy_q;
  assign io.key_num_out     = key_out_q;
  assign io.health_out      = hp_out_q;

endmodule

// File: tb/tb_tile_resolver.sv
// Directed bench for tile_resolver with a latency-2 map RAM model.
module tb_tile_resolver;
  import map_pkg::*;

  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_resolver_if bus ();

  tile_resolver #(.RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .io(bus));

  // map RAM model: single writer process, bench pokes go through poke_*
  logic [15:0] mem [0:255];
  logic [15:0] rd_pipe [0:RD_LAT-1];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

  always @(posedge clk) begin
    if (bus.bRAM_map_wr) mem[bus.bRAM_map_addr[7:0]] <= bus.bRAM_map_dwrite;
    if (poke_en) mem[poke_addr] <= poke_data;
    rd_pipe[0] <= mem[bus.bRAM_map_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bRAM_map_data = rd_pipe[RD_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // One request; returns latency (-1 if no pulse in 20 cycles), pulse kind,
  // write count/position/data/address and the address shown during PRECHK.
  task automatic do_move(input logic [3:0] x, y, px, py, k, input logic [7:0] h,
                         output int lat, output bit acc, output bit rej,
                         output int nwr, output int wr_at, output logic [15:0] wd,
                         output logic [18:0] wa, output logic [18:0] a_pre,
                         output logic [18:0] a_chk);
    a_pre = bus.bRAM_map_addr;
    bus.ask_move = 1'b1; bus.ask_x = x; bus.ask_y = y;
    bus.player_x = px; bus.player_y = py; bus.key_num = k; bus.health = h;
    @(posedge clk); #1;
    bus.ask_move = 1'b0;
    a_chk = bus.bRAM_map_addr;
    lat = -1; acc = 0; rej = 0; nwr = 0; wr_at = -1; wd = '0; wa = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.bRAM_map_wr) begin nwr++; wr_at = n; wd = bus.bRAM_map_dwrite; wa = bus.bRAM_map_addr; end
      if (bus.accept_move || bus.reject_move) begin
        lat = n; acc = bus.accept_move; rej = bus.reject_move; break;
      end
    end
  endtask

  int lat, nwr, wr_at;
  bit acc, rej;
  logic [15:0] wd;
  logic [18:0] wa, a_pre, a_chk;

  task automatic test_reset;
    bus.ask_move = 0; bus.ask_x = 0; bus.ask_y = 0; bus.player_x = 0; bus.player_y = 0;
    bus.key_num = 0; bus.health = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({bus.accept_move, bus.reject_move, bus.busy, bus.bRAM_map_wr} !== 4'b0)
      begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.accept_move, bus.reject_move, bus.busy, bus.bRAM_map_wr}); end
    n_cmp++; if ({bus.goto_x, bus.goto_y, bus.key_num_out, bus.health_out, bus.bRAM_map_dwrite} !== 36'h0)
      begin n_bad++; $display("FAIL reset_data: nonzero data outputs"); end
    n_cmp++; if (bus.bRAM_map_addr !== 19'h0)
      begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.bRAM_map_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_floor;
    poke(8'h34, 16'h0000);
    do_move(4, 3, 3, 3, 2, 6, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 5 || acc !== 1) begin n_bad++; $display("FAIL floor_lat: got lat %0d acc %0d want 5 1", lat, acc); end
    n_cmp++; if ({bus.goto_x, bus.goto_y} !== 8'h43) begin n_bad++; $display("FAIL floor_goto: got %h want 43", {bus.goto_x, bus.goto_y}); end
    n_cmp++; if (bus.key_num_out !== 4'd2 || bus.health_out !== 8'd6) begin n_bad++; $display("FAIL floor_kh: got %0d %0d want 2 6", bus.key_num_out, bus.health_out); end
    n_cmp++; if (nwr !== 0) begin n_bad++; $display("FAIL floor_nowr: got %0d writes want 0", nwr); end
    n_cmp++; if (a_chk !== 19'h34) begin n_bad++; $display("FAIL floor_addr: got %h want 34", a_chk); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL floor_busy_pulse: got %b want 1", bus.busy); end
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.accept_move !== 1'b0) begin n_bad++; $display("FAIL floor_after: busy %b acc %b want 0 0", bus.busy, bus.accept_move); end
    n_cmp++; if ({bus.goto_x, bus.goto_y} !== 8'h43) begin n_bad++; $display("FAIL floor_hold: got %h want 43", {bus.goto_x, bus.goto_y}); end
  endtask

  task automatic test_geometry;
    do_move(5, 3, 3, 3, 7, 9, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 2 || rej !== 1) begin n_bad++; $display("FAIL far_lat: got lat %0d rej %0d want 2 1", lat, rej); end
    n_cmp++; if ({bus.goto_x, bus.goto_y, bus.key_num_out, bus.health_out} !== 20'h33_7_09) begin n_bad++; $display("FAIL far_out: got %h want 33709", {bus.goto_x, bus.goto_y, bus.key_num_out, bus.health_out}); end
    n_cmp++; if (a_chk !== a_pre) begin n_bad++; $display("FAIL far_noread: addr %h want %h", a_chk, a_pre); end
    @(posedge clk); #1;
    do_move(13, 0, 12, 0, 1, 4, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 2 || rej !== 1) begin n_bad++; $display("FAIL oob_lat: got lat %0d rej %0d want 2 1", lat, rej); end
    n_cmp++; if ({bus.goto_x, bus.goto_y} !== 8'hC0 || a_chk !== a_pre) begin n_bad++; $display("FAIL oob_out: goto %h addr %h want c0 %h", {bus.goto_x, bus.goto_y}, a_chk, a_pre); end
    @(posedge clk); #1;
    do_move(6, 6, 6, 6, 1, 4, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 2 || rej !== 1) begin n_bad++; $display("FAIL same_lat: got lat %0d rej %0d want 2 1", lat, rej); end
    @(posedge clk); #1;
  endtask

  task automatic test_key;
    poke(8'h23, 16'h1232);
    do_move(3, 2, 3, 3, 15, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 6 || acc !== 1) begin n_bad++; $display("FAIL key_lat: got lat %0d acc %0d want 6 1", lat, acc); end
    n_cmp++; if (bus.key_num_out !== 4'd15) begin n_bad++; $display("FAIL key_sat: got %0d want 15", bus.key_num_out); end
    n_cmp++; if (nwr !== 1 || wr_at !== 5 || wd !== 16'h1230 || wa !== 19'h23) begin n_bad++; $display("FAIL key_wr: n %0d at %0d d %h a %h want 1 5 1230 23", nwr, wr_at, wd, wa); end
    @(posedge clk); #1;
    n_cmp++; if (mem[8'h23] !== 16'h1230) begin n_bad++; $display("FAIL key_mem: got %h want 1230", mem[8'h23]); end
    poke(8'h32, 16'h0002);
    do_move(2, 3, 3, 3, 4, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (acc !== 1 || bus.key_num_out !== 4'd5) begin n_bad++; $display("FAIL key_inc: acc %0d key %0d want 1 5", acc, bus.key_num_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_door;
    poke(8'h43, 16'h0003);
    do_move(3, 4, 3, 3, 0, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 5 || rej !== 1 || nwr !== 0) begin n_bad++; $display("FAIL door_locked: lat %0d rej %0d wr %0d want 5 1 0", lat, rej, nwr); end
    n_cmp++; if ({bus.goto_x, bus.goto_y, bus.key_num_out} !== 12'h330) begin n_bad++; $display("FAIL door_locked_out: got %h want 330", {bus.goto_x, bus.goto_y, bus.key_num_out}); end
    @(posedge clk); #1;
    do_move(3, 4, 3, 3, 2, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 6 || acc !== 1 || bus.key_num_out !== 4'd1) begin n_bad++; $display("FAIL door_open: lat %0d acc %0d key %0d want 6 1 1", lat, acc, bus.key_num_out); end
    n_cmp++; if (nwr !== 1 || wd !== 16'h0000 || wa !== 19'h43) begin n_bad++; $display("FAIL door_wr: n %0d d %h a %h want 1 0 43", nwr, wd, wa); end
    @(posedge clk); #1;
  endtask

  task automatic test_monster_potion;
    poke(8'h34, 16'h0004);
    do_move(4, 3, 3, 3, 1, 3, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (rej !== 1 || nwr !== 0 || bus.health_out !== 8'd3) begin n_bad++; $display("FAIL mon_weak: rej %0d wr %0d hp %0d want 1 0 3", rej, nwr, bus.health_out); end
    @(posedge clk); #1;
    do_move(4, 3, 3, 3, 1, 10, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 6 || acc !== 1 || bus.health_out !== 8'd7 || nwr !== 1) begin n_bad++; $display("FAIL mon_kill: lat %0d acc %0d hp %0d wr %0d want 6 1 7 1", lat, acc, bus.health_out, nwr); end
    @(posedge clk); #1;
    poke(8'h32, 16'h8005);
    do_move(2, 3, 3, 3, 1, 7, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (acc !== 1 || bus.health_out !== 8'd10 || wd !== 16'h8000) begin n_bad++; $display("FAIL potion_sat: acc %0d hp %0d wd %h want 1 10 8000", acc, bus.health_out, wd); end
    @(posedge clk); #1;
    poke(8'h32, 16'h0005);
    do_move(2, 3, 3, 3, 1, 2, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (acc !== 1 || bus.health_out !== 8'd7) begin n_bad++; $display("FAIL potion_add: acc %0d hp %0d want 1 7", acc, bus.health_out); end
    @(posedge clk); #1;
    poke(8'h34, 16'h0001);
    do_move(4, 3, 3, 3, 1, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 5 || rej !== 1 || nwr !== 0) begin n_bad++; $display("FAIL wall: lat %0d rej %0d wr %0d want 5 1 0", lat, rej, nwr); end
    @(posedge clk); #1;
    poke(8'h34, 16'h0009);
    do_move(4, 3, 3, 3, 1, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (rej !== 1 || {bus.goto_x, bus.goto_y} !== 8'h33) begin n_bad++; $display("FAIL unknown_tile: rej %0d goto %h want 1 33", rej, {bus.goto_x, bus.goto_y}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int pulses;
    poke(8'h34, 16'h0000);
    bus.ask_move = 1; bus.ask_x = 4; bus.ask_y = 3; bus.player_x = 3; bus.player_y = 3;
    bus.key_num = 1; bus.health = 5;
    @(posedge clk); #1; bus.ask_move = 0;
    @(posedge clk); #1;
    bus.ask_move = 1; bus.ask_x = 9; bus.ask_y = 9;   // lands in READ
    @(posedge clk); #1; bus.ask_move = 0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      if (bus.accept_move || bus.reject_move) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL b2b_count: got %0d pulses want 1", pulses); end
    n_cmp++; if ({bus.goto_x, bus.goto_y} !== 8'h43) begin n_bad++; $display("FAIL b2b_goto: got %h want 43", {bus.goto_x, bus.goto_y}); end
  endtask

  task automatic test_reset_mid;
    int pulses, wrs;
    poke(8'h55, 16'h0002);
    bus.ask_move = 1; bus.ask_x = 5; bus.ask_y = 5; bus.player_x = 5; bus.player_y = 4;
    bus.key_num = 3; bus.health = 5;
    @(posedge clk); #1; bus.ask_move = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0; wrs = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.accept_move || bus.reject_move) pulses++;
      if (bus.bRAM_map_wr) wrs++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 0 || wrs !== 0) begin n_bad++; $display("FAIL rstmid_quiet: pulses %0d writes %0d want 0 0", pulses, wrs); end
    n_cmp++; if (mem[8'h55] !== 16'h0002 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_state: mem %h busy %b want 0002 0", mem[8'h55], bus.busy); end
    do_move(5, 5, 5, 4, 3, 5, lat, acc, rej, nwr, wr_at, wd, wa, a_pre, a_chk);
    n_cmp++; if (lat !== 6 || acc !== 1 || bus.key_num_out !== 4'd4 || nwr !== 1) begin n_bad++; $display("FAIL rstmid_next: lat %0d acc %0d key %0d wr %0d want 6 1 4 1", lat, acc, bus.key_num_out, nwr); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_floor;
    test_geometry;
    test_key;
    test_door;
    test_monster_potion;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
